// File: rtl/axilite_regs_pkg.sv
// Purpose: shared constants, types and helpers for the AXI4-Lite stats register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axilite_regs_pkg;

  // Byte offsets within the 4 KiB register window
  localparam logic [11:0] OFF_ID       = 12'h000;
  localparam logic [11:0] OFF_CTRL     = 12'h004;
  localparam logic [11:0] OFF_SCRATCH  = 12'h008;
  localparam logic [11:0] OFF_CNT_CLR  = 12'h00C;
  localparam logic [11:0] OFF_CNT_BASE = 12'h010;

  // Word indices used by the decoders (ADDR[11:2])
  localparam logic [9:0] IDX_ID       = OFF_ID[11:2];
  localparam logic [9:0] IDX_CTRL     = OFF_CTRL[11:2];
  localparam logic [9:0] IDX_SCRATCH  = OFF_SCRATCH[11:2];
  localparam logic [9:0] IDX_CNT_CLR  = OFF_CNT_CLR[11:2];
  localparam logic [9:0] IDX_CNT_BASE = OFF_CNT_BASE[11:2];

  localparam logic [31:0] ID_VALUE = 32'h4D43_0001;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  // Merge new_val into old_val on the bytes selected by strb
  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_val[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axilite_stats_regs_if.sv
// Purpose: AXI4-Lite bus bundle between the bridge master port and the register file.
// Latency: n/a (wires only).
// Backpressure: standard per-channel VALID/READY.
interface axilite_stats_regs_if;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  modport master (
    output AWADDR, AWVALID, input  AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input  BRESP, BVALID, output BREADY,
    output ARADDR, ARVALID, input ARREADY,
    input  RDATA, RRESP, RVALID, output RREADY
  );

  modport slave (
    input  AWADDR, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input  ARADDR, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );
endinterface

// File: rtl/axilite_stats_regs_sat_counter.sv
// Purpose: saturating event counter with synchronous clear (clear beats increment).
// Latency: count visible one cycle after the inc/clr strobe.
// Backpressure: none; every strobe is absorbed, increments past all-ones are dropped.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Clear has priority; increment stops at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/axilite_stats_regs.sv
// Purpose: AXI4-Lite register file: ID, CTRL, SCRATCH, counter clear and saturating stats counters.
// Latency: BVALID/register update 1 cycle after the later of AW/W; RVALID 1 cycle after AR.
// Backpressure: BVALID/RVALID held until accepted; AW/W/AR stall while a response is pending.
module axilite_stats_regs
  import axilite_regs_pkg::*;
#(
  parameter int          NUM_CNT    = 4,
  parameter int          CNT_W      = 32,
  parameter logic [31:0] RESET_CTRL = 32'h0000_0000
) (
  input  logic                 axi_clk,
  input  logic                 axi_reset,
  axilite_stats_regs_if.slave  s_axi,
  input  logic [NUM_CNT-1:0]   cnt_inc,
  output logic [31:0]          ctrl_out
);

  // First word index past the last implemented counter
  localparam logic [9:0] IDX_LIMIT = IDX_CNT_BASE + 10'(NUM_CNT);

  // Write path state
  wr_state_t   r_wstate;
  logic        r_aw_full;
  logic        r_w_full;
  logic        r_awready;
  logic        r_wready;
  logic        r_bvalid;
  logic [1:0]  r_bresp;
  logic [9:0]  r_awidx;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_ctrl;
  logic [31:0] r_scratch;

  // Read path state
  rd_state_t   r_rstate;
  logic        r_arready;
  logic        r_rvalid;
  logic [1:0]  r_rresp;
  logic [31:0] r_rdata;

  logic               w_aw_hs;
  logic               w_w_hs;
  logic               w_commit;
  logic               w_wr_err;
  logic [9:0]         w_wr_idx;
  logic [31:0]        w_wr_data;
  logic [3:0]         w_wr_strb;
  logic [NUM_CNT-1:0] w_clr;
  logic [CNT_W-1:0]   w_cnt [NUM_CNT];
  logic               w_ar_hs;
  logic [9:0]         w_ar_idx;
  logic [31:0]        w_rd_data;
  logic               w_rd_err;
  logic               w_unused;

  // Only ADDR[11:2] takes part in decode
  assign w_unused = ^{s_axi.AWADDR[31:12], s_axi.AWADDR[1:0],
                      s_axi.ARADDR[31:12], s_axi.ARADDR[1:0]};

  assign w_aw_hs = s_axi.AWVALID & r_awready;
  assign w_w_hs  = s_axi.WVALID  & r_wready;

  // The write commits on the edge that completes the AW/W pair, using live bus
  // values for whichever half arrives on that edge
  assign w_wr_idx  = r_aw_full ? r_awidx : s_axi.AWADDR[11:2];
  assign w_wr_data = r_w_full  ? r_wdata : s_axi.WDATA;
  assign w_wr_strb = r_w_full  ? r_wstrb : s_axi.WSTRB;
  assign w_commit  = (r_wstate == W_IDLE) & (r_aw_full | w_aw_hs) & (r_w_full | w_w_hs);
  assign w_wr_err  = (w_wr_idx >= IDX_LIMIT);
  assign w_clr     = (w_commit && (w_wr_idx == IDX_CNT_CLR)) ? w_wr_data[NUM_CNT-1:0] : '0;

  // Write handshake FSM: independent AW/W latches, single B response per pair
  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      r_wstate  <= W_IDLE;
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_awidx   <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_aw_full <= 1'b1;
            r_awidx   <= s_axi.AWADDR[11:2];
          end
          if (w_w_hs) begin
            r_w_full <= 1'b1;
            r_wdata  <= s_axi.WDATA;
            r_wstrb  <= s_axi.WSTRB;
          end
          if (w_commit) begin
            r_wstate  <= W_RESP;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
          end else begin
            r_awready <= ~(r_aw_full | w_aw_hs);
            r_wready  <= ~(r_w_full | w_w_hs);
          end
        end
        W_RESP: begin
          if (s_axi.BREADY) begin
            r_wstate  <= W_IDLE;
            r_bvalid  <= 1'b0;
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Byte-enabled CTRL/SCRATCH update on the commit edge; other targets leave them alone
  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      r_ctrl    <= RESET_CTRL;
      r_scratch <= '0;
    end else if (w_commit) begin
      if (w_wr_idx == IDX_CTRL)    r_ctrl    <= apply_strb(r_ctrl, w_wr_data, w_wr_strb);
      if (w_wr_idx == IDX_SCRATCH) r_scratch <= apply_strb(r_scratch, w_wr_data, w_wr_strb);
    end
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk (axi_clk),
      .rst (axi_reset),
      .inc (cnt_inc[g]),
      .clr (w_clr[g]),
      .cnt (w_cnt[g])
    );
  end

  assign w_ar_hs  = s_axi.ARVALID & r_arready;
  assign w_ar_idx = s_axi.ARADDR[11:2];

  // Read decode from current register values (pre-update on a coincident write/increment)
  always_comb begin
    w_rd_data = '0;
    w_rd_err  = 1'b0;
    if (w_ar_idx == IDX_ID) begin
      w_rd_data = ID_VALUE;
    end else if (w_ar_idx == IDX_CTRL) begin
      w_rd_data = r_ctrl;
    end else if (w_ar_idx == IDX_SCRATCH) begin
      w_rd_data = r_scratch;
    end else if (w_ar_idx == IDX_CNT_CLR) begin
      w_rd_data = '0;
    end else begin
      w_rd_err = 1'b1;
      for (int i = 0; i < NUM_CNT; i++) begin
        if (w_ar_idx == (IDX_CNT_BASE + 10'(i))) begin
          w_rd_data = 32'(w_cnt[i]);
          w_rd_err  = 1'b0;
        end
      end
    end
  end

  // Read handshake FSM: capture on AR, hold R until accepted
  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rstate  <= R_DATA;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rdata   <= w_rd_data;
            r_rresp   <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi.RREADY) begin
            r_rstate  <= R_IDLE;
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign s_axi.AWREADY = r_awready;
  assign s_axi.WREADY  = r_wready;
  assign s_axi.BVALID  = r_bvalid;
  assign s_axi.BRESP   = r_bresp;
  assign s_axi.ARREADY = r_arready;
  assign s_axi.RVALID  = r_rvalid;
  assign s_axi.RRESP   = r_rresp;
  assign s_axi.RDATA   = r_rdata;
  assign ctrl_out      = r_ctrl;

endmodule

// File: tb/tb_axilite_stats_regs.sv
// Purpose: directed self-checking bench for axilite_stats_regs (NUM_CNT=4, CNT_W=4).
// Latency: checks response timing relative to AW/W/AR handshakes.
// Backpressure: exercises held BVALID/RVALID with READY low.
module tb_axilite_stats_regs;

  localparam logic [31:0] RST_CTRL = 32'hCAFE_0000;
  localparam logic [31:0] ID_VAL   = 32'h4D43_0001;

  logic       axi_clk;
  logic       axi_reset;
  logic [3:0] cnt_inc;
  logic [31:0] ctrl_out;

  int n_pass  = 0;
  int n_total = 0;

  axilite_stats_regs_if u_if ();

  axilite_stats_regs #(
    .NUM_CNT    (4),
    .CNT_W      (4),
    .RESET_CTRL (RST_CTRL)
  ) dut (
    .axi_clk   (axi_clk),
    .axi_reset (axi_reset),
    .s_axi     (u_if),
    .cnt_inc   (cnt_inc),
    .ctrl_out  (ctrl_out)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic send_aw(input logic [31:0] addr);
    bit done = 1'b0;
    u_if.AWADDR  = addr;
    u_if.AWVALID = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge axi_clk);
      if (u_if.AWREADY) done = 1'b1;
      @(posedge axi_clk); #1;
    end
    u_if.AWVALID = 1'b0;
    if (!done) check("aw_timeout", 32'(u_if.AWREADY), 32'd1);
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
    bit done = 1'b0;
    u_if.WDATA  = data;
    u_if.WSTRB  = strb;
    u_if.WVALID = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge axi_clk);
      if (u_if.WREADY) done = 1'b1;
      @(posedge axi_clk); #1;
    end
    u_if.WVALID = 1'b0;
    if (!done) check("w_timeout", 32'(u_if.WREADY), 32'd1);
  endtask

  task automatic send_ar(input logic [31:0] addr);
    bit done = 1'b0;
    u_if.ARADDR  = addr;
    u_if.ARVALID = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge axi_clk);
      if (u_if.ARREADY) done = 1'b1;
      @(posedge axi_clk); #1;
    end
    u_if.ARVALID = 1'b0;
    if (!done) check("ar_timeout", 32'(u_if.ARREADY), 32'd1);
  endtask

  task automatic take_b(output logic [1:0] resp);
    bit done = 1'b0;
    resp = 2'b11;
    u_if.BREADY = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge axi_clk);
      if (u_if.BVALID) begin
        done = 1'b1;
        resp = u_if.BRESP;
      end
      @(posedge axi_clk); #1;
    end
    u_if.BREADY = 1'b0;
    if (!done) check("b_timeout", 32'(u_if.BVALID), 32'd1);
  endtask

  task automatic take_r(output logic [31:0] data, output logic [1:0] resp);
    bit done = 1'b0;
    data = 32'hDEAD_BEEF;
    resp = 2'b11;
    u_if.RREADY = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge axi_clk);
      if (u_if.RVALID) begin
        done = 1'b1;
        data = u_if.RDATA;
        resp = u_if.RRESP;
      end
      @(posedge axi_clk); #1;
    end
    u_if.RREADY = 1'b0;
    if (!done) check("r_timeout", 32'(u_if.RVALID), 32'd1);
  endtask

  task automatic write_reg(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    fork
      send_aw(addr);
      send_w(data, strb);
    join
    take_b(resp);
  endtask

  task automatic chk_rd(input string tag, input logic [31:0] addr,
                        input logic [31:0] exp_data, input logic [1:0] exp_resp);
    logic [31:0] d;
    logic [1:0]  r;
    send_ar(addr);
    take_r(d, r);
    check({tag, "_data"}, d, exp_data);
    check({tag, "_resp"}, 32'(r), 32'(exp_resp));
  endtask

  // Directed sequence
  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    axi_reset    = 1'b0;
    cnt_inc      = '0;
    u_if.AWADDR  = '0; u_if.AWVALID = 1'b0;
    u_if.WDATA   = '0; u_if.WSTRB   = '0; u_if.WVALID = 1'b0;
    u_if.BREADY  = 1'b0;
    u_if.ARADDR  = '0; u_if.ARVALID = 1'b0;
    u_if.RREADY  = 1'b0;
    #2 axi_reset = 1'b1;

    // Reset values
    repeat (3) @(posedge axi_clk);
    #1;
    check("rst_awready", 32'(u_if.AWREADY), 32'd0);
    check("rst_wready",  32'(u_if.WREADY),  32'd0);
    check("rst_arready", 32'(u_if.ARREADY), 32'd0);
    check("rst_bvalid",  32'(u_if.BVALID),  32'd0);
    check("rst_rvalid",  32'(u_if.RVALID),  32'd0);
    check("rst_bresp",   32'(u_if.BRESP),   32'd0);
    check("rst_rresp",   32'(u_if.RRESP),   32'd0);
    check("rst_rdata",   u_if.RDATA,        32'd0);
    check("rst_ctrl",    ctrl_out,          RST_CTRL);
    axi_reset = 1'b0;
    @(negedge axi_clk);
    check("arready_before_first_edge", 32'(u_if.ARREADY), 32'd0);
    @(posedge axi_clk); #1;
    check("arready_first_edge", 32'(u_if.ARREADY), 32'd1);
    check("awready_first_edge", 32'(u_if.AWREADY), 32'd1);
    check("wready_first_edge",  32'(u_if.WREADY),  32'd1);

    // ID read with latency check
    u_if.ARADDR  = 32'h0000_0000;
    u_if.ARVALID = 1'b1;
    @(negedge axi_clk);
    check("id_rvalid_before_hs", 32'(u_if.RVALID), 32'd0);
    @(posedge axi_clk); #1;
    u_if.ARVALID = 1'b0;
    check("id_rvalid_after_hs", 32'(u_if.RVALID), 32'd1);
    check("id_rdata",  u_if.RDATA, ID_VAL);
    check("id_rresp",  32'(u_if.RRESP), 32'd0);
    check("id_arready_busy", 32'(u_if.ARREADY), 32'd0);
    take_r(d, r);

    // W three cycles ahead of AW, partial strobe on CTRL, BREADY held low
    send_w(32'hAABB_CCDD, 4'b0101);
    check("wfirst_wready",  32'(u_if.WREADY),  32'd0);
    check("wfirst_awready", 32'(u_if.AWREADY), 32'd1);
    repeat (2) @(posedge axi_clk);
    #1;
    check("wfirst_no_bvalid", 32'(u_if.BVALID), 32'd0);
    check("wfirst_ctrl_unchanged", ctrl_out, RST_CTRL);
    send_aw(32'h0000_0004);
    check("ctrl_bvalid", 32'(u_if.BVALID), 32'd1);
    check("ctrl_bresp",  32'(u_if.BRESP),  32'd0);
    check("ctrl_strb_value", ctrl_out, 32'hCABB_00DD);
    repeat (2) @(posedge axi_clk);
    #1;
    check("bhold_awready", 32'(u_if.AWREADY), 32'd0);
    check("bhold_wready",  32'(u_if.WREADY),  32'd0);
    check("bhold_bvalid",  32'(u_if.BVALID),  32'd1);
    take_b(r);
    check("bdone_bvalid",  32'(u_if.BVALID),  32'd0);
    check("bdone_awready", 32'(u_if.AWREADY), 32'd1);
    chk_rd("rd_ctrl", 32'h0000_0004, 32'hCABB_00DD, 2'b00);

    // SCRATCH read held with RREADY low while SCRATCH is rewritten
    send_ar(32'h0000_0008);
    check("scr_hold_rdata0", u_if.RDATA, 32'd0);
    write_reg(32'h0000_0008, 32'h1234_5678, 4'hF, r);
    check("scr_wr_bresp", 32'(r), 32'd0);
    for (int i = 0; i < 2; i++) begin
      check("scr_hold_rdata", u_if.RDATA, 32'd0);
      check("scr_hold_rvalid", 32'(u_if.RVALID), 32'd1);
      @(posedge axi_clk); #1;
    end
    take_r(d, r);
    check("scr_old_value", d, 32'd0);
    chk_rd("rd_scr_new", 32'h0000_0008, 32'h1234_5678, 2'b00);

    // Read CTRL on the same edge its write commits: old value returned
    u_if.ARADDR = 32'h0000_0004; u_if.ARVALID = 1'b1;
    u_if.AWADDR = 32'h0000_0004; u_if.AWVALID = 1'b1;
    u_if.WDATA  = 32'h1122_3344; u_if.WSTRB   = 4'hF; u_if.WVALID = 1'b1;
    @(posedge axi_clk); #1;
    u_if.ARVALID = 1'b0; u_if.AWVALID = 1'b0; u_if.WVALID = 1'b0;
    check("coinc_rdata_old", u_if.RDATA, 32'hCABB_00DD);
    check("coinc_ctrl_new",  ctrl_out,   32'h1122_3344);
    check("coinc_bvalid",    32'(u_if.BVALID), 32'd1);
    take_r(d, r);
    take_b(r);

    // Counter 1 saturates at 4'hF after 20 increments
    cnt_inc = 4'b0010;
    repeat (20) @(posedge axi_clk);
    #1;
    cnt_inc = 4'b0000;
    chk_rd("cnt1_sat", 32'h0000_0014, 32'h0000_000F, 2'b00);
    chk_rd("cnt0_idle", 32'h0000_0010, 32'h0000_0000, 2'b00);
    cnt_inc = 4'b0100;
    repeat (3) @(posedge axi_clk);
    #1;
    cnt_inc = 4'b0000;
    chk_rd("cnt2_three", 32'h0000_0018, 32'h0000_0003, 2'b00);

    // Clear counter 1 on the same edge as an increment; high bits and WSTRB ignored
    u_if.AWADDR = 32'h0000_000C; u_if.AWVALID = 1'b1;
    u_if.WDATA  = 32'hFFFF_FFF2; u_if.WSTRB   = 4'h0; u_if.WVALID = 1'b1;
    cnt_inc = 4'b0010;
    @(posedge axi_clk); #1;
    u_if.AWVALID = 1'b0; u_if.WVALID = 1'b0;
    cnt_inc = 4'b0000;
    take_b(r);
    check("clr_bresp", 32'(r), 32'd0);
    chk_rd("cnt1_cleared", 32'h0000_0014, 32'h0000_0000, 2'b00);
    chk_rd("cnt2_kept",    32'h0000_0018, 32'h0000_0003, 2'b00);
    chk_rd("cnt_clr_read", 32'h0000_000C, 32'h0000_0000, 2'b00);

    // Counter read on an increment edge returns the pre-increment value
    u_if.ARADDR = 32'h0000_0018; u_if.ARVALID = 1'b1;
    cnt_inc = 4'b0100;
    @(posedge axi_clk); #1;
    u_if.ARVALID = 1'b0;
    cnt_inc = 4'b0000;
    take_r(d, r);
    check("cnt2_pre_inc", d, 32'h0000_0003);
    chk_rd("cnt2_post_inc", 32'h0000_0018, 32'h0000_0004, 2'b00);

    // Unmapped and read-only targets
    chk_rd("rd_0x40", 32'h0000_0040, 32'h0000_0000, 2'b10);
    chk_rd("rd_0x20", 32'h0000_0020, 32'h0000_0000, 2'b10);
    write_reg(32'h0000_0020, 32'hFFFF_FFFF, 4'hF, r);
    check("wr_0x20_bresp", 32'(r), 32'd2);
    check("wr_0x20_ctrl",  ctrl_out, 32'h1122_3344);
    chk_rd("wr_0x20_scr", 32'h0000_0008, 32'h1234_5678, 2'b00);
    write_reg(32'h0000_001C, 32'hFFFF_FFFF, 4'hF, r);
    check("wr_cnt3_bresp", 32'(r), 32'd0);
    chk_rd("cnt3_untouched", 32'h0000_001C, 32'h0000_0000, 2'b00);
    write_reg(32'h0000_0000, 32'h0000_0000, 4'hF, r);
    check("wr_id_bresp", 32'(r), 32'd0);
    chk_rd("id_unchanged", 32'h0000_0000, ID_VAL, 2'b00);

    // Address bits outside [11:2] are ignored
    chk_rd("alias_ctrl", 32'h0000_1004, 32'h1122_3344, 2'b00);
    write_reg(32'hFFFF_F00B, 32'h0000_00EE, 4'b0001, r);
    check("alias_wr_bresp", 32'(r), 32'd0);
    chk_rd("alias_scr", 32'h0000_0008, 32'h1234_56EE, 2'b00);

    // Reset while a B response is pending
    u_if.AWADDR = 32'h0000_0004; u_if.AWVALID = 1'b1;
    u_if.WDATA  = 32'h5555_5555; u_if.WSTRB   = 4'hF; u_if.WVALID = 1'b1;
    @(posedge axi_clk); #1;
    u_if.AWVALID = 1'b0; u_if.WVALID = 1'b0;
    check("pre_rst_bvalid", 32'(u_if.BVALID), 32'd1);
    check("pre_rst_ctrl",   ctrl_out, 32'h5555_5555);
    @(posedge axi_clk); #1;
    axi_reset = 1'b1;
    #1;
    check("midrst_bvalid",  32'(u_if.BVALID),  32'd0);
    check("midrst_ctrl",    ctrl_out,          RST_CTRL);
    check("midrst_awready", 32'(u_if.AWREADY), 32'd0);
    repeat (2) @(posedge axi_clk);
    #1;
    axi_reset = 1'b0;
    @(posedge axi_clk); #1;
    check("postrst_no_b", 32'(u_if.BVALID), 32'd0);
    write_reg(32'h0000_0004, 32'h0000_00A5, 4'hF, r);
    check("postrst_bresp", 32'(r), 32'd0);
    check("postrst_ctrl",  ctrl_out, 32'h0000_00A5);
    chk_rd("postrst_cnt2", 32'h0000_0018, 32'h0000_0000, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
